fetch_unit: RTL and testbench

- Instruction fetch stage. Produces the instruction stream that the decode/control stage consumes: opcode, mode, valid PC.
- Consumes that stage's resolved control results in the reverse direction: redirect, halt, siic, rti.
- Owns the PC and the EPC.
- Talks to a variable-latency instruction memory through a req/done handshake.
- Buffers up to 2 fetched instructions so decode stalls do not drop data.

---
 rtl/cpu_pkg.sv | 27 ++
 rtl/fetch_buffer.sv | 53 +++++
 rtl/fetch_unit.sv | 139 +++++++++++++
 tb/tb_fetch_unit.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared widths, reset/exception vectors, opcodes and fetch
//               state encoding for the CPU front end.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;
    localparam int WORD_W   = 16;
    localparam int OPCODE_W = 5;

    localparam logic [WORD_W-1:0] RESET_PC_DEFAULT   = 16'h0000;
    localparam logic [WORD_W-1:0] EXC_VECTOR_DEFAULT = 16'h0002;

    localparam logic [OPCODE_W-1:0] HALT = 5'b00000;
    localparam logic [OPCODE_W-1:0] SIIC = 5'b00010;
    localparam logic [OPCODE_W-1:0] RTI  = 5'b00011;

    localparam logic [0:0] FETCH_RUN    = 1'b0;
    localparam logic [0:0] FETCH_HALTED = 1'b1;

    // Instruction addresses advance by one 16-bit word and wrap at 2^16.
    function automatic logic [WORD_W-1:0] pc_inc(input logic [WORD_W-1:0] pc);
        return pc + 16'd2;
    endfunction
endpackage
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_buffer
// Description : DEPTH-entry synchronous FIFO of fetched {instr, pc} pairs;
//               flush beats push, push allowed when full if popping.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_buffer #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] c_one = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_push;
    logic             w_pop;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                     (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_one;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_one;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !i_flush && w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end
endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage: owns PC/EPC, issues single
//               outstanding imem requests and buffers words for decode.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter logic [WORD_W-1:0] EXC_VECTOR = EXC_VECTOR_DEFAULT,
    parameter int                DEPTH      = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [WORD_W-1:0] imem_addr,
    input  logic [WORD_W-1:0] imem_rdata,
    input  logic              imem_done,
    output logic              id_valid,
    output logic [WORD_W-1:0] id_instr,
    output logic [WORD_W-1:0] id_pc,
    output logic [WORD_W-1:0] id_pc_plus2,
    input  logic              id_ready,
    input  logic              redirect,
    input  logic [WORD_W-1:0] redirect_pc,
    input  logic              halt,
    input  logic              siic,
    input  logic              rti,
    output logic [WORD_W-1:0] epc,
    output logic              err
);
    logic [0:0]          r_state;
    logic [0:0]          w_state_next;
    logic [WORD_W-1:0]   r_pc;
    logic [WORD_W-1:0]   r_epc;
    logic [WORD_W-1:0]   r_req_addr;
    logic                r_outstanding;
    logic                r_squash;
    logic                r_err;

    logic                w_run;
    logic                w_event;
    logic                w_issue;
    logic                w_inflight;
    logic                w_complete;
    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic [2*WORD_W-1:0] w_head;

    assign w_run      = (r_state == FETCH_RUN);
    assign w_event    = w_run && (halt || siic || rti || redirect);
    // No launch on a control-event cycle: the old pc is about to be replaced.
    assign w_issue    = !rst && w_run && !r_outstanding && !w_full && !w_event;
    assign w_inflight = r_outstanding || w_issue;
    assign w_complete = imem_done && w_inflight;
    assign w_push     = w_complete && !r_squash && !w_event && w_run;
    assign w_pop      = id_valid && id_ready;

    fetch_buffer #(
        .DEPTH (DEPTH),
        .WIDTH (2*WORD_W)
    ) u_buffer (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_event),
        .i_wdata ({imem_rdata, imem_addr}),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= FETCH_RUN;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (w_run && halt) w_state_next = FETCH_HALTED;
    end

    always_comb begin
        imem_req  = r_outstanding || w_issue;
        imem_addr = r_outstanding ? r_req_addr : r_pc;
        id_valid  = !w_empty;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_epc         <= '0;
            r_req_addr    <= RESET_PC;
            r_outstanding <= 1'b0;
            r_squash      <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            if (imem_done && !w_inflight) r_err <= 1'b1;

            if (w_complete) begin
                r_outstanding <= 1'b0;
                r_squash      <= 1'b0;
            end else if (w_issue) begin
                r_outstanding <= 1'b1;
                r_req_addr    <= r_pc;
            end else if (w_event && r_outstanding) begin
                r_squash      <= 1'b1;
            end

            // Nested priority: only the highest event present acts.
            if (w_event) begin
                if (halt) begin
                    r_pc <= r_pc;
                end else if (siic) begin
                    r_epc <= redirect_pc;
                    r_pc  <= EXC_VECTOR;
                end else if (rti) begin
                    r_pc <= r_epc;
                end else begin
                    r_pc <= redirect_pc;
                end
            end else if (w_push) begin
                r_pc <= pc_inc(r_pc);
            end
        end
    end

    assign id_instr    = w_empty ? '0 : w_head[2*WORD_W-1:WORD_W];
    assign id_pc       = w_empty ? '0 : w_head[WORD_W-1:0];
    assign id_pc_plus2 = w_empty ? '0 : pc_inc(w_head[WORD_W-1:0]);
    assign epc         = r_epc;
    assign err         = r_err;
endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed self-checking bench for fetch_unit with a
//               programmable-latency instruction memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_done;
    logic        id_valid;
    logic [15:0] id_instr;
    logic [15:0] id_pc;
    logic [15:0] id_pc_plus2;
    logic        id_ready = 1'b1;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        halt = 1'b0;
    logic        siic = 1'b0;
    logic        rti = 1'b0;
    logic [15:0] epc;
    logic        err;

    int          lat = 0;
    logic        spur = 1'b0;
    int          wait_cnt;
    int          n_vec = 0;
    int          n_bad = 0;
    logic [15:0] ea;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_done   (imem_done),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .id_pc       (id_pc),
        .id_pc_plus2 (id_pc_plus2),
        .id_ready    (id_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .siic        (siic),
        .rti         (rti),
        .epc         (epc),
        .err         (err)
    );

    // Memory answers lat cycles after the request first appears; lat=0 is same-cycle.
    always_ff @(posedge clk) wait_cnt <= (imem_req && !imem_done) ? wait_cnt + 1 : 0;
    assign imem_done  = (imem_req && (wait_cnt == lat)) || spur;
    assign imem_rdata = imem_addr ^ 16'hBEEF;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_reset(input int l, input logic rdy);
        @(negedge clk);
        rst = 1'b1; halt = 1'b0; siic = 1'b0; rti = 1'b0; redirect = 1'b0;
        redirect_pc = 16'h0000; spur = 1'b0; lat = l; id_ready = rdy;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_req",   imem_req,    16'h0000);
        chk("rst_addr",  imem_addr,   16'h0000);
        chk("rst_valid", id_valid,    16'h0000);
        chk("rst_instr", id_instr,    16'h0000);
        chk("rst_pc",    id_pc,       16'h0000);
        chk("rst_pc2",   id_pc_plus2, 16'h0000);
        chk("rst_epc",   epc,         16'h0000);
        chk("rst_err",   err,         16'h0000);
        rst = 1'b0;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Stream, zero-wait memory, decode always ready
        do_reset(0, 1'b1);
        chk("s_req0",  imem_req,  16'h0001);
        chk("s_addr0", imem_addr, 16'h0000);
        for (int k = 0; k < 6; k++) begin
            cyc(); #1;
            ea = 16'(2 * k);
            chk("s_valid", id_valid,    16'h0001);
            chk("s_pc",    id_pc,       ea);
            chk("s_instr", id_instr,    ea ^ 16'hBEEF);
            chk("s_pc2",   id_pc_plus2, ea + 16'h0002);
        end

        // Backpressure: two entries buffered, request held low
        do_reset(0, 1'b0);
        repeat (9) cyc();
        #1;
        chk("bp_req",   imem_req, 16'h0000);
        chk("bp_valid", id_valid, 16'h0001);
        chk("bp_head",  id_pc,    16'h0000);
        cyc(); id_ready = 1'b1; #1;
        chk("bp_pop0",  id_pc,    16'h0000);
        chk("bp_req_f", imem_req, 16'h0000);
        cyc(); #1;
        chk("bp_pop1",  id_pc,     16'h0002);
        chk("bp_next",  imem_addr, 16'h0004);
        chk("bp_req1",  imem_req,  16'h0001);
        cyc(); #1;
        chk("bp_pop2",  id_pc,     16'h0004);

        // Redirect with 3-cycle memory latency
        do_reset(3, 1'b0);
        repeat (3) cyc();
        cyc(); #1;
        chk("rd_valid", id_valid,  16'h0001);
        chk("rd_head",  id_pc,     16'h0000);
        chk("rd_addr",  imem_addr, 16'h0002);
        cyc(); redirect = 1'b1; redirect_pc = 16'h0040; #1;
        chk("rd_held",  imem_req,  16'h0001);
        cyc(); redirect = 1'b0; #1;
        chk("rd_flush", id_valid,  16'h0000);
        chk("rd_hreq",  imem_req,  16'h0001);
        chk("rd_haddr", imem_addr, 16'h0002);
        cyc(); #1;
        chk("rd_dreq",  imem_req,  16'h0001);
        cyc(); #1;
        chk("rd_squash", id_valid, 16'h0000);
        chk("rd_target", imem_addr, 16'h0040);
        chk("rd_treq",   imem_req,  16'h0001);
        repeat (4) cyc();
        #1;
        chk("rd_nvalid", id_valid, 16'h0001);
        chk("rd_npc",    id_pc,    16'h0040);
        chk("rd_ninstr", id_instr, 16'h0040 ^ 16'hBEEF);

        // siic then rti (rti beats a same-cycle redirect)
        do_reset(0, 1'b1);
        cyc(); siic = 1'b1; redirect_pc = 16'h0122; #1;
        cyc(); siic = 1'b0; #1;
        chk("si_epc",   epc,       16'h0122);
        chk("si_valid", id_valid,  16'h0000);
        chk("si_addr",  imem_addr, 16'h0002);
        chk("si_req",   imem_req,  16'h0001);
        cyc(); rti = 1'b1; redirect = 1'b1; redirect_pc = 16'h0300; #1;
        chk("si_head",  id_pc,     16'h0002);
        cyc(); rti = 1'b0; redirect = 1'b0; #1;
        chk("rti_addr",  imem_addr, 16'h0122);
        chk("rti_valid", id_valid,  16'h0000);
        chk("rti_epc",   epc,       16'h0122);
        cyc(); #1;
        chk("rti_pc",    id_pc,     16'h0122);
        chk("rti_instr", id_instr,  16'h0122 ^ 16'hBEEF);

        // Halt with a request outstanding
        do_reset(3, 1'b1);
        cyc(); halt = 1'b1; #1;
        cyc(); halt = 1'b0; redirect = 1'b1; redirect_pc = 16'h0080; #1;
        chk("h_req",   imem_req,  16'h0001);
        chk("h_addr",  imem_addr, 16'h0000);
        chk("h_valid", id_valid,  16'h0000);
        cyc(); #1;
        chk("h_dreq",  imem_req,  16'h0001);
        for (int k = 0; k < 5; k++) begin
            cyc(); #1;
            chk("h_idle_req",   imem_req,  16'h0000);
            chk("h_idle_valid", id_valid,  16'h0000);
            chk("h_idle_addr",  imem_addr, 16'h0000);
        end
        do_reset(0, 1'b1);
        chk("h_rst_req",  imem_req,  16'h0001);
        chk("h_rst_addr", imem_addr, 16'h0000);
        cyc(); #1;
        chk("h_rst_pc",   id_pc,     16'h0000);

        // Wrap at 0xFFFE, then a spurious done while idle
        cyc(); redirect = 1'b1; redirect_pc = 16'hFFFE; #1;
        cyc(); redirect = 1'b0; #1;
        chk("w_addr",  imem_addr, 16'hFFFE);
        chk("w_req",   imem_req,  16'h0001);
        cyc(); #1;
        chk("w_pc",    id_pc,       16'hFFFE);
        chk("w_pc2",   id_pc_plus2, 16'h0000);
        chk("w_instr", id_instr,    16'hFFFE ^ 16'hBEEF);
        chk("w_next",  imem_addr,   16'h0000);
        cyc(); #1;
        chk("w_pcz",   id_pc,       16'h0000);
        cyc(); id_ready = 1'b0; #1;
        chk("e_pre",   err,      16'h0000);
        cyc(); #1;
        chk("e_idle",  imem_req, 16'h0000);
        spur = 1'b1;
        cyc(); spur = 1'b0; #1;
        chk("e_set",   err,      16'h0001);
        repeat (3) cyc();
        #1;
        chk("e_hold",  err,      16'h0001);
        chk("e_valid", id_valid, 16'h0001);
        do_reset(0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
